// File: rtl/bitonic_sort8_pipe.sv
// bitonic_sort8_pipe: eight-key bitonic sorting network, one register per
// compare-exchange stage (6 stages), valid/ready handshake with global stall.
//
// Parameters:
//   DATA_W     width of each key
//   SIGNED_CMP 0 = unsigned keys, 1 = two's-complement keys
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready = advance)
//   in_data             eight keys, lane k at [k*DATA_W +: DATA_W]
//   in_desc             0 = ascending, 1 = descending (per vector)
//   out_valid/out_ready output handshake
//   out_data            sorted keys, same lane packing
//   out_desc            in_desc of the vector on out_data
module bitonic_sort8_pipe #(
    parameter int DATA_W     = 8,
    parameter int SIGNED_CMP = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*DATA_W-1:0] in_data,
    input  logic                in_desc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*DATA_W-1:0] out_data,
    output logic                out_desc
);

    localparam int LANES  = 8;
    localparam int STAGES = 6;

    // Partner distance of each compare-exchange stage.
    function automatic int dist_of(input int s);
        case (s)
            0:       return 1;
            1:       return 2;
            2:       return 1;
            3:       return 4;
            4:       return 2;
            default: return 1;
        endcase
    endfunction

    // Size of the bitonic block being merged by each stage.
    function automatic int blk_of(input int s);
        case (s)
            0:       return 2;
            1:       return 4;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    // Strict greater-than; equal keys never swap.
    function automatic logic key_gt(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        if (SIGNED_CMP != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    logic [DATA_W-1:0] src_d [STAGES][LANES];
    logic [DATA_W-1:0] nxt_d [STAGES][LANES];
    logic [DATA_W-1:0] d_q   [STAGES][LANES];
    logic              src_desc [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] desc_q;
    logic              advance;

    // Whole pipe moves together; it only holds when the output is stuck.
    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;
    assign out_valid = valid_q[STAGES-1];
    assign out_desc  = desc_q[STAGES-1];

    // Stage inputs: stage 0 from the port, later stages from registers.
    for (genvar k = 0; k < LANES; k++) begin : g_in
        assign src_d[0][k] = in_data[k*DATA_W +: DATA_W];
        assign out_data[k*DATA_W +: DATA_W] = d_q[STAGES-1][k];
    end

    assign src_desc[0] = in_desc;

    for (genvar s = 1; s < STAGES; s++) begin : g_src
        assign src_desc[s] = desc_q[s-1];
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            assign src_d[s][k] = d_q[s-1][k];
        end
    end

    // Compare-exchange network. Merges of 2- and 4-blocks run descending
    // on even blocks and ascending on odd ones, so the final 8-wide merge
    // sees desc-then-asc halves and runs ascending; in_desc mirrors all.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int DIST = dist_of(s);
        localparam int BLK  = blk_of(s);
        for (genvar i = 0; i < LANES; i++) begin : g_cmp
            if ((i & DIST) == 0) begin : g_pair
                localparam logic BASE_DESC =
                    (BLK == LANES) ? 1'b0 : ((i & BLK) == 0);
                logic pair_desc;
                logic swap;
                logic [DATA_W-1:0] lo;
                logic [DATA_W-1:0] hi;

                assign lo        = src_d[s][i];
                assign hi        = src_d[s][i+DIST];
                assign pair_desc = BASE_DESC ^ src_desc[s];
                assign swap      = pair_desc ? key_gt(hi, lo)
                                             : key_gt(lo, hi);

                assign nxt_d[s][i]      = swap ? hi : lo;
                assign nxt_d[s][i+DIST] = swap ? lo : hi;
            end
        end
    end

    // Stage registers; a non-accepted input cycle enters as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            desc_q  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                for (int k = 0; k < LANES; k++) begin
                    d_q[s][k] <= '0;
                end
            end
        end else if (advance) begin
            valid_q <= {valid_q[STAGES-2:0], in_valid};
            desc_q  <= {desc_q[STAGES-2:0], in_desc};
            for (int s = 0; s < STAGES; s++) begin
                for (int k = 0; k < LANES; k++) begin
                    d_q[s][k] <= nxt_d[s][k];
                end
            end
        end
    end

endmodule
